rr_burst_sched: RTL and testbench
=================================

Name: rr_burst_sched

Overview:
- Round-robin scheduler that shares one burst down-counter resource between NREQ requesters.
- Each requester has a fixed burst length, held in an unpacked-array parameter of per-requester counts, one 32-bit entry per requester.
- The block grants one requester at a time, holds the grant for exactly that requester's burst length, then rotates priority.
- It sits in front of any shared single-owner datapath that must be time-sliced.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- BURST_LEN, all entries 16, unpacked array bit [31:0] [NREQ-1:0]; burst length in cycles per requester; an entry of 0 is treated as 1.
- CNT_W, 16, width of the internal counter and of the remaining output; lengths above 2^CNT_W-1 saturate to 2^CNT_W-1.

Ports:
- clk, input, 1, sole clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- req, input, NREQ, per-requester request level; must be held until granted.
- gnt, output, NREQ, one-hot grant, or all zero.
- gnt_id, output, $clog2(NREQ), index of the current or most recent grantee.
- busy, output, 1, high while in GRANT.
- remaining, output, CNT_W, grant cycles left including the current cycle; 0 when not in GRANT.
- done, output, 1, single-cycle pulse on the last grant cycle of a completed burst.
- abort, output, 1, single-cycle pulse when the grantee drops req mid-burst.

Behaviour:
- Reset, while reset is high at an edge:
  - state=IDLE, gnt=0, gnt_id=0, busy=0, remaining=0, done=0, abort=0.
  - Priority pointer = 0, so requester 0 has highest priority.
  - Reset mid-burst discards the burst immediately; no done or abort pulse.
- All outputs are registered; there is no combinational path from req to gnt.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is set at an edge, the winner is the first set bit searching from ptr upward, modulo NREQ.
  - Next cycle: state=GRANT, gnt=1<<winner, gnt_id=winner, remaining=eff_len(winner), busy=1.
  - If req is all zero, stay in IDLE.
  - Latency from req seen to gnt high: 1 cycle.
- GRANT:
  - remaining decrements by 1 each cycle.
  - gnt stays high for exactly eff_len cycles.
  - done=1 in the cycle where remaining==1, coincident with the last gnt cycle.
  - Next cycle: state=GAP, gnt=0, busy=0, remaining=0, ptr=(gnt_id+1) mod NREQ.
- Early release:
  - If req[gnt_id] is low at an edge in GRANT and remaining>1, abort=1 in the following cycle.
  - In that same cycle: state=GAP, gnt=0, remaining=0, ptr advances as for a completed burst.
  - If req drops at the edge where remaining==1, the burst is complete: done fires, abort does not.
- GAP:
  - Exactly one cycle with gnt=0; this is bus turnaround.
  - Arbitration is performed in GAP with the same rule as IDLE: a pending req gives GRANT next cycle, otherwise IDLE.
  - Back-to-back bursts are therefore separated by exactly 1 idle gnt cycle.
- Fairness:
  - A requester holding req continuously is granted within (NREQ-1) bursts of other requesters.
  - The just-served requester has lowest priority at the next arbitration.
- Width rules:
  - eff_len = max(1, min(BURST_LEN[i], 2^CNT_W-1)), computed at elaboration.
  - The counter never wraps below 0.
- Simultaneous events:
  - done and abort are never both high.
  - gnt is never multi-hot.
  - req bits for non-granted requesters are ignored during GRANT.

Test Plan:
- Defaults (NREQ=2, BURST_LEN={16,16}), req=2'b01 held → gnt=01 one cycle after the req edge, for exactly 16 cycles; remaining counts 16..1; done on the 16th cycle; then gnt=00 for one cycle.
- req=2'b11 held continuously, BURST_LEN={3,5} → gnt sequence 01×3, 00×1, 10×5, 00×1, 01×3, …; done pulses at cycles 3, 9, 13 after the first grant.
- BURST_LEN={0,2} with req=2'b01 → gnt=01 for exactly 1 cycle, done coincident with it; remaining shows 1 then 0.
- Abort: BURST_LEN={16,16}, req[0] dropped after 4 grant cycles → abort=1 for one cycle, gnt=00, remaining=0; done never asserts; a pending req[1] is then granted after the single GAP cycle.
- Reset mid-burst: reset asserted with remaining=9 → next cycle all outputs 0, state IDLE; with req=11 held, the first grant goes to requester 0.
- Saturation: CNT_W=4, BURST_LEN={20,1}, req=01 → gnt held for 15 cycles; remaining never exceeds 15.

Source files
------------

// File: rtl/rr_burst_sched.sv
// Round-robin scheduler: grants one requester at a time for its fixed burst length, then
// inserts a single turnaround cycle before the next arbitration.
module rr_burst_sched #(
    parameter int unsigned  NREQ                 = 2,
    parameter bit [31:0]    BURST_LEN [NREQ-1:0] = '{default: 32'd16},
    parameter int unsigned  CNT_W                = 16,
    localparam int unsigned ID_W                 = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             abort
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_t;

    state_t           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [CNT_W-1:0] eff_len [NREQ];
    logic             found;
    logic [ID_W:0]    cand;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  next_ptr;

    // Zero-length bursts become 1; lengths beyond the counter range saturate.
    for (genvar i = 0; i < NREQ; i++) begin : g_len
        localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;
        localparam longint unsigned Raw    = 64'(BURST_LEN[i]);
        localparam longint unsigned Eff    = (Raw == 64'd0) ? 64'd1 :
                                             ((Raw > CntMax) ? CntMax : Raw);
        assign eff_len[i] = CNT_W'(Eff);
    end

    always_comb begin
        found  = 1'b0;
        cand   = '0;
        winner = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (ID_W+1)'(ptr_q) + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            unique case (state_q)
                StIdle, StGap: begin
                    if (found) begin
                        state_q   <= StGrant;
                        gnt       <= NREQ'(1) << winner;
                        gnt_id    <= winner;
                        busy      <= 1'b1;
                        remaining <= eff_len[winner];
                        done      <= (eff_len[winner] == CNT_W'(1));
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (remaining == CNT_W'(1) || !req[gnt_id]) begin
                        // Completion takes precedence over a drop on the final cycle.
                        state_q   <= StGap;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        remaining <= '0;
                        ptr_q     <= next_ptr;
                        abort     <= (remaining != CNT_W'(1));
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        done      <= (remaining == CNT_W'(2));
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_sched.sv
// Scoreboard bench for rr_burst_sched: four instances with different burst tables, expected
// grant cycles queued by the stimulus and popped by a negedge monitor.
module tb_rr_burst_sched;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        id;
        logic [15:0] rem;
        logic        done;
        logic        abort;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [1:0]  req0, req1, req2, req3;
    logic [1:0]  gnt0, gnt1, gnt2, gnt3;
    logic        id0, id1, id2, id3;
    logic        busy0, busy1, busy2, busy3;
    logic [15:0] rem0, rem1, rem2;
    logic [3:0]  rem3;
    logic        done0, done1, done2, done3;
    logic        abort0, abort1, abort2, abort3;

    rec_t q0[$], q1[$], q2[$], q3[$];
    int   checks = 0;
    int   errors = 0;

    rr_burst_sched u0 (
        .clk(clk), .reset(rst_a), .req(req0), .gnt(gnt0), .gnt_id(id0), .busy(busy0),
        .remaining(rem0), .done(done0), .abort(abort0)
    );

    // Array is [1:0], so positional patterns list index 1 first.
    rr_burst_sched #(.BURST_LEN('{32'd5, 32'd3})) u1 (
        .clk(clk), .reset(rst_b), .req(req1), .gnt(gnt1), .gnt_id(id1), .busy(busy1),
        .remaining(rem1), .done(done1), .abort(abort1)
    );

    rr_burst_sched #(.BURST_LEN('{32'd2, 32'd0})) u2 (
        .clk(clk), .reset(rst_b), .req(req2), .gnt(gnt2), .gnt_id(id2), .busy(busy2),
        .remaining(rem2), .done(done2), .abort(abort2)
    );

    rr_burst_sched #(.CNT_W(4), .BURST_LEN('{32'd1, 32'd20})) u3 (
        .clk(clk), .reset(rst_b), .req(req3), .gnt(gnt3), .gnt_id(id3), .busy(busy3),
        .remaining(rem3), .done(done3), .abort(abort3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input rec_t r);
        case (inst)
            0: q0.push_back(r);
            1: q1.push_back(r);
            2: q2.push_back(r);
            default: q3.push_back(r);
        endcase
    endtask

    // Queue `count` grant cycles of a burst of length `len`, remaining counting down from len.
    task automatic push_burst(input int inst, input logic [1:0] g, input logic id,
                              input int len, input int count);
        rec_t r;
        for (int k = 0; k < count; k++) begin
            r.gnt   = g;
            r.id    = id;
            r.rem   = 16'(len - k);
            r.done  = (len - k == 1);
            r.abort = 1'b0;
            push(inst, r);
        end
    endtask

    task automatic mon(input int inst, input rec_t act);
        rec_t e;
        bit   have;
        have = 1'b0;
        if (act.gnt === 2'b00 && act.done === 1'b0 && act.abort === 1'b0) return;
        case (inst)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL mon%0d unexpected output: gnt=%b id=%0d rem=%0d done=%b abort=%b",
                     inst, act.gnt, act.id, act.rem, act.done, act.abort);
        end else if (act !== e) begin
            errors++;
            $display("FAIL mon%0d got gnt=%b id=%0d rem=%0d done=%b abort=%b, expected gnt=%b id=%0d rem=%0d done=%b abort=%b",
                     inst, act.gnt, act.id, act.rem, act.done, act.abort,
                     e.gnt, e.id, e.rem, e.done, e.abort);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rec_t'{gnt0, id0, rem0, done0, abort0});
        mon(1, rec_t'{gnt1, id1, rem1, done1, abort1});
        mon(2, rec_t'{gnt2, id2, rem2, done2, abort2});
        mon(3, rec_t'{gnt3, id3, {12'd0, rem3}, done3, abort3});
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        req0  = '0;
        req1  = '0;
        req2  = '0;
        req3  = '0;
        tick(2);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("reset gnt", 32'(gnt0), 0);
        chk("reset gnt_id", 32'(id0), 0);
        chk("reset busy", 32'(busy0), 0);
        chk("reset remaining", 32'(rem0), 0);
        chk("reset done", 32'(done0), 0);
        chk("reset abort", 32'(abort0), 0);

        // Single requester, full 16-cycle burst then one gap cycle.
        req0 = 2'b01;
        push_burst(0, 2'b01, 1'b0, 16, 16);
        tick(16);
        req0 = 2'b00;
        tick(1);
        chk("t1 gap gnt", 32'(gnt0), 0);
        chk("t1 gap busy", 32'(busy0), 0);
        chk("t1 gap remaining", 32'(rem0), 0);
        tick(1);

        // Pointer now at 1: requester 1 wins, then reset at remaining==9.
        req0 = 2'b11;
        push_burst(0, 2'b10, 1'b1, 16, 8);
        tick(8);
        chk("pre-reset remaining", 32'(rem0), 9);
        rst_a = 1'b1;
        tick(1);
        chk("mid reset gnt", 32'(gnt0), 0);
        chk("mid reset gnt_id", 32'(id0), 0);
        chk("mid reset busy", 32'(busy0), 0);
        chk("mid reset remaining", 32'(rem0), 0);
        chk("mid reset done", 32'(done0), 0);
        chk("mid reset abort", 32'(abort0), 0);
        rst_a = 1'b0;

        // Requester 0 wins after reset, drops after 4 cycles; requester 1 follows the abort.
        push_burst(0, 2'b01, 1'b0, 16, 4);
        push(0, rec_t'{2'b00, 1'b0, 16'd0, 1'b0, 1'b1});
        push_burst(0, 2'b10, 1'b1, 16, 16);
        tick(4);
        req0 = 2'b10;
        tick(1);
        chk("abort pulse", 32'(abort0), 1);
        chk("abort gnt", 32'(gnt0), 0);
        chk("abort remaining", 32'(rem0), 0);
        chk("abort done", 32'(done0), 0);
        tick(16);
        req0 = 2'b00;
        tick(1);
        chk("t2 gap gnt", 32'(gnt0), 0);
        tick(1);

        // Both requesting, lengths {3,5}.
        req1 = 2'b11;
        push_burst(1, 2'b01, 1'b0, 3, 3);
        push_burst(1, 2'b10, 1'b1, 5, 5);
        push_burst(1, 2'b01, 1'b0, 3, 3);
        tick(4);
        chk("rr gap1 gnt", 32'(gnt1), 0);
        chk("rr gap1 busy", 32'(busy1), 0);
        chk("rr gap1 gnt_id", 32'(id1), 0);
        tick(6);
        chk("rr gap2 gnt", 32'(gnt1), 0);
        chk("rr gap2 gnt_id", 32'(id1), 1);
        tick(3);
        req1 = 2'b00;
        tick(2);

        // Zero-length entry behaves as length 1.
        req2 = 2'b01;
        push_burst(2, 2'b01, 1'b0, 1, 1);
        tick(1);
        req2 = 2'b00;
        tick(1);
        chk("len0 gap remaining", 32'(rem2), 0);
        chk("len0 gap gnt", 32'(gnt2), 0);
        tick(1);

        // CNT_W=4 saturates a 20-cycle request to 15.
        req3 = 2'b01;
        push_burst(3, 2'b01, 1'b0, 15, 15);
        tick(15);
        req3 = 2'b00;
        tick(1);
        chk("sat gap gnt", 32'(gnt3), 0);
        chk("sat gap remaining", 32'(rem3), 0);
        tick(2);

        chk("q0 drained", 32'(q0.size()), 0);
        chk("q1 drained", 32'(q1.size()), 0);
        chk("q2 drained", 32'(q2.size()), 0);
        chk("q3 drained", 32'(q3.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
